uart_tx_arbiter: RTL and testbench

//  Shares one UART TX core (serializer/parity/mux/FSM) among NUM_REQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end for a shared UART TX core: picks one byte source,
// launches a single frame with a one-cycle pulse, then follows tx_busy
// until the core is free again. A core that never raises busy is flagged.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_busy,
  output logic [DATA_W-1:0]             tx_p_data,
  output logic                          tx_data_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          err_timeout,
  input  logic                          err_clr
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic           hs;
  logic           timeout_hit;
  logic           illegal;
  logic [CW-1:0]  cnt;

  // Round-robin scan starting at rr_ptr; index wraps by compare, so
  // non-power-of-two requester counts never alias onto a missing slot.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign hs          = (state == IDLE) && !tx_busy && found;
  assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (cnt == CW'(TIMEOUT - 1));
  assign illegal     = !(state inside {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE});

  // One-hot accept only while idle and the core is free; held low in reset.
  always_comb begin
    req_ready = '0;
    if (hs && RST) req_ready[win] = 1'b1;
  end

  // Next-state logic for the launch/track sequence.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (hs) state_n = LAUNCH;
      LAUNCH:    state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)          state_n = WAIT_DONE;
        else if (timeout_hit) state_n = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // State, captured byte/grant, round-robin pointer, wait counter and error flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
      grant_id      <= '0;
      err_timeout   <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_n;
      tx_data_valid <= hs;
      if (hs) begin
        tx_p_data <= req_data[win*DATA_W +: DATA_W];
        grant_id  <= win;
        rr_ptr    <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      // Cleared in every other state so WAIT_BUSY always starts at zero.
      cnt <= (state == WAIT_BUSY) ? cnt + 1'b1 : '0;
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (illegal) begin
        tx_p_data     <= '0;
        tx_data_valid <= 1'b0;
        grant_id      <= '0;
        rr_ptr        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reset values, a vector table of single
// handshakes, directed multi-cycle corners, and a randomized run checked
// against a frame-level timing model of arbiter plus TX core.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int T = 15;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic [1:0]  grant_id;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  // Second instance with three requesters for the wrap case.
  logic [2:0]  v3 = '0;
  logic [2:0]  rdy3;
  logic        busy3;
  logic [7:0]  pd3;
  logic        dv3;
  logic [1:0]  gid3;
  logic        err3;
  logic        clr3 = 1'b0;
  logic [2:0]  b3cnt;
  int          g3[$];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(T)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_p_data(tx_p_data),
    .tx_data_valid(tx_data_valid), .grant_id(grant_id),
    .err_timeout(err_timeout), .err_clr(err_clr));

  uart_tx_arbiter #(.NUM_REQ(3), .DATA_W(8), .TIMEOUT(T)) dut3 (
    .CLK(CLK), .RST(RST), .req_valid(v3), .req_data(24'h030201),
    .req_ready(rdy3), .tx_busy(busy3), .tx_p_data(pd3),
    .tx_data_valid(dv3), .grant_id(gid3),
    .err_timeout(err3), .err_clr(clr3));

  // Simple TX core for dut3: busy from the cycle after launch, for 4 cycles.
  always @(posedge CLK or negedge RST) begin
    if (!RST)          b3cnt <= '0;
    else if (dv3)      b3cnt <= 3'd4;
    else if (b3cnt != 0) b3cnt <= b3cnt - 3'd1;
  end
  assign busy3 = (b3cnt != 0);

  always @(negedge CLK) if (RST && dv3) g3.push_back(int'(gid3));

  // Frame-level model state.
  int         cyc, free_at, launch_cyc, busy_lo, busy_hi, to_cyc, m_rr;
  bit         m_err;
  logic [7:0] m_data;
  logic [1:0] m_gid;
  int         grants[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int scan(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    RST = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0; err_clr = 1'b0; v3 = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    cyc = 0; free_at = 0; launch_cyc = -1; busy_lo = 0; busy_hi = 0; to_cyc = -1;
    m_rr = 0; m_err = 1'b0; m_data = '0; m_gid = '0;
  endtask

  // fmode: 0 random frames (some never raise busy), 1 busy after 1 held 11, 2 busy never rises.
  task automatic run(input int n, input bit rnd, input logic [3:0] vfix, input int fmode, input int clr_at);
    int w, d, h, L;
    logic [3:0] er;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      cyc++;
      tx_busy   = (cyc >= busy_lo) && (cyc < busy_hi);
      req_valid = rnd ? 4'($urandom_range(0, 15)) : vfix;
      req_data  = $urandom;
      err_clr   = (cyc == clr_at) || (rnd && $urandom_range(0, 9) == 0);
      @(negedge CLK);
      w  = (cyc >= free_at && !tx_busy) ? scan(req_valid, m_rr) : -1;
      er = (w >= 0) ? 4'(1 << w) : 4'b0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("tx_data_valid", 32'(tx_data_valid), 32'(cyc == launch_cyc));
      chk("tx_p_data", 32'(tx_p_data), 32'(m_data));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
      if (cyc == to_cyc) m_err = 1'b1;
      else if (err_clr)  m_err = 1'b0;
      if (w >= 0) begin
        L = cyc + 1;
        launch_cyc = L;
        m_data = req_data[w*8 +: 8];
        m_gid  = 2'(w);
        m_rr   = (w + 1) % N;
        grants.push_back(w);
        if (fmode == 2 || (fmode == 0 && $urandom_range(0, 4) == 0)) begin
          busy_lo = 0; busy_hi = 0; free_at = L + T + 1; to_cyc = L + T;
        end else begin
          d = (fmode == 1) ? 1 : $urandom_range(1, 3);
          h = (fmode == 1) ? 11 : $urandom_range(1, 6);
          busy_lo = L + d; busy_hi = L + d + h; free_at = L + d + h + 1; to_cyc = -1;
        end
      end
    end
    err_clr = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  er;
    logic [1:0]  eg;
    logic [7:0]  ed;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0100, 32'h00A5_0000, 1'b0, 4'b0100, 2'd2, 8'hA5};
    tbl[1] = '{4'b1111, 32'h4433_2211, 1'b0, 4'b0001, 2'd0, 8'h11};
    tbl[2] = '{4'b1000, 32'h5A00_0000, 1'b0, 4'b1000, 2'd3, 8'h5A};
    tbl[3] = '{4'b0000, 32'hFFFF_FFFF, 1'b0, 4'b0000, 2'd0, 8'h00};
    tbl[4] = '{4'b1111, 32'h1234_5678, 1'b1, 4'b0000, 2'd0, 8'h00};
    tbl[5] = '{4'b0110, 32'h00C3_B200, 1'b0, 4'b0010, 2'd1, 8'hB2};
    tbl[6] = '{4'b1010, 32'h0000_E700, 1'b0, 4'b0010, 2'd1, 8'hE7};

    // Reset state, with requests pending and the core idle.
    cyc = 0;
    RST = 1'b0; req_valid = 4'b1111; req_data = 32'hDEADBEEF;
    #12;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_data_valid", 32'(tx_data_valid), 0);
    chk("rst_tx_p_data", 32'(tx_p_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);

    // Vector table: one handshake from a fresh reset, then the launch cycle.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      @(posedge CLK); #1;
      req_valid = tbl[i].v; req_data = tbl[i].data; tx_busy = tbl[i].busy;
      @(negedge CLK);
      chk("tbl_req_ready", 32'(req_ready), 32'(tbl[i].er));
      @(posedge CLK); #1;
      req_valid = '0; tx_busy = 1'b0;
      @(negedge CLK);
      chk("tbl_tx_data_valid", 32'(tx_data_valid), 32'(tbl[i].er != 0));
      chk("tbl_tx_p_data", 32'(tx_p_data), 32'(tbl[i].ed));
      chk("tbl_grant_id", 32'(grant_id), 32'(tbl[i].eg));
    end

    // All requesters valid with a regular busy profile: strict rotation.
    do_reset();
    grants.delete();
    run(70, 1'b0, 4'b1111, 1, -1);
    chk("rot_count", 32'(grants.size() >= 5), 1);
    if (grants.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rot_grant", 32'(grants[i]), 32'(i % N));

    // Three requesters, 0 and 2 valid: rotation wraps past the last index.
    do_reset();
    g3.delete();
    v3 = 3'b101;
    repeat (60) @(posedge CLK);
    v3 = '0;
    chk("wrap_count", 32'(g3.size() >= 4), 1);
    if (g3.size() >= 4)
      for (int i = 0; i < 4; i++) chk("wrap_grant", 32'(g3[i]), 32'((i % 2) * 2));

    // Core never raises busy: timeout, then the next grant still proceeds.
    do_reset();
    grants.delete();
    run(20, 1'b0, 4'b1111, 2, -1);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_next_n", 32'(grants.size()), 2);
    if (grants.size() >= 2) chk("to_next_grant", 32'(grants[1]), 1);
    run(2, 1'b0, 4'b0000, 2, 21);
    chk("to_clr", 32'(err_timeout), 0);

    // Timeout and err_clr land on the same cycle: set wins.
    do_reset();
    run(18, 1'b0, 4'b0100, 2, 17);
    chk("err_prio", 32'(err_timeout), 1);

    // Core busy while idle: no accept until busy falls.
    do_reset();
    @(posedge CLK); #1;
    tx_busy = 1'b1; req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("busy_hold_ready", 32'(req_ready), 0);
      @(posedge CLK); #1;
    end
    tx_busy = 1'b0;
    @(negedge CLK);
    chk("busy_fall_ready", 32'(req_ready), 32'b0001);

    // Reset mid-frame (second frame, grant 1, in WAIT_DONE).
    do_reset();
    run(20, 1'b0, 4'b1111, 1, -1);
    chk("pre_rst_grant", 32'(grant_id), 1);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_tx_data_valid", 32'(tx_data_valid), 0);
    chk("mid_rst_tx_p_data", 32'(tx_p_data), 0);
    chk("mid_rst_grant_id", 32'(grant_id), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    chk("mid_rst_err", 32'(err_timeout), 0);
    do_reset();
    grants.delete();
    run(3, 1'b0, 4'b1111, 1, -1);
    chk("post_rst_n", 32'(grants.size()), 1);
    if (grants.size() >= 1) chk("post_rst_grant", 32'(grants[0]), 0);

    // Randomized traffic against the frame-level model.
    do_reset();
    run(3000, 1'b1, 4'b0000, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
